// File: rtl/gf64_pkg.sv
// Shared widths, stage payload types and GF(2^64) reduction for the carry-less multiplier path.
// No latency; pure types and a combinational helper function. No flow control.
// Users of the shared multiplier import this package for widths, stage types and the reduction.
package gf64_pkg;

    localparam int GF64_W  = 64;
    localparam int GF64_PW = 128;

    // Low terms of x^64 + x^4 + x^3 + x + 1; the x^64 term is implicit.
    localparam logic [GF64_W-1:0] GF64_POLY_LO = 64'h1B;

    typedef struct packed {
        logic              id;
        logic [GF64_W-1:0] a;
        logic [GF64_W-1:0] b;
    } gf64_s1_t;

    typedef struct packed {
        logic               id;
        logic [GF64_PW-1:0] data;
    } gf64_s2_t;

    // Two folds suffice: the first leaves at most 4 overflow bits (poly degree 4),
    // and folding those lands below bit 8.
    function automatic logic [GF64_W-1:0] gf64_reduce(input logic [GF64_PW-1:0] p);
        logic [GF64_W+3:0] t;
        logic [7:0]        u;
        t = '0;
        u = '0;
        for (int i = 0; i < 5; i++) begin
            if (GF64_POLY_LO[i]) begin
                t = t ^ ({4'b0, p[GF64_PW-1:GF64_W]} << i);
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (GF64_POLY_LO[i]) begin
                u = u ^ ({4'b0, t[GF64_W+3:GF64_W]} << i);
            end
        end
        return p[GF64_W-1:0] ^ t[GF64_W-1:0] ^ {56'b0, u};
    endfunction

endpackage

// File: rtl/gf64_mul.sv
// 64x64 carry-less (GF(2)[x]) multiplier producing the full 128-bit product.
// Purely combinational, zero latency.
// No flow control; the caller registers operands and product.
module gf64_mul
    import gf64_pkg::*;
(
    input  logic [GF64_W-1:0]  a,
    input  logic [GF64_W-1:0]  b,
    output logic [GF64_PW-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < GF64_W; i++) begin
            if (b[i]) begin
                p = p ^ ({{GF64_W{1'b0}}, a} << i);
            end
        end
    end

endmodule

// File: rtl/gf64_mul_arb.sv
// Round-robin two-requester front end for one shared gf64_mul, optional GF(2^64) reduction.
// Latency: accepted at edge k, rsp_valid after edge k+1 (S1 operands, S2 result).
// Backpressure: rsp_ready low stalls S2, then S1; readies drop to 0 when both stages are full.
module gf64_mul_arb
    import gf64_pkg::*;
#(
    parameter bit REDUCE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [GF64_W-1:0]  req0_a,
    input  logic [GF64_W-1:0]  req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [GF64_W-1:0]  req1_a,
    input  logic [GF64_W-1:0]  req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [GF64_PW-1:0] rsp_data
);

    logic               s1_valid;
    gf64_s1_t           s1;
    logic               s2_valid;
    gf64_s2_t           s2;
    logic               prio;

    logic               s2_adv;
    logic               s1_adv;
    logic               grant;
    logic               accept;
    logic [GF64_PW-1:0] prod;
    logic [GF64_PW-1:0] result;

    assign s2_adv = !s2_valid || rsp_ready;
    assign s1_adv = !s1_valid || s2_adv;

    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = prio;
        end else begin
            grant = req1_valid;
        end
    end

    // Readies are masked during reset so nothing is handed over only to be wiped.
    assign req0_ready = !rst && s1_adv && req0_valid && !grant;
    assign req1_ready = !rst && s1_adv && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;

    gf64_mul u_mul (
        .a (s1.a),
        .b (s1.b),
        .p (prod)
    );

    assign result = REDUCE ? {{GF64_W{1'b0}}, gf64_reduce(prod)} : prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
            s2_valid <= 1'b0;
            s2       <= '0;
            prio     <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2 <= '{id: s1.id, data: result};
                end
            end
            if (s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1 <= grant ? '{id: 1'b1, a: req1_a, b: req1_b}
                                : '{id: 1'b0, a: req0_a, b: req0_b};
                end
            end
            if (accept) begin
                prio <= !grant;
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2.id;
    assign rsp_data  = s2.data;

endmodule
